// File: rtl/bidir_pkg.sv
// Shared types and reset constants for the device-side bidirectional bus transceiver.
package bidir_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    LISTEN = 2'd0,
    TURN   = 2'd1,
    DRIVE  = 2'd2
  } xcvr_state_e;

  localparam xcvr_state_e RST_STATE = LISTEN;
  localparam logic        RST_DIR_Q = 1'b1;
  localparam logic        RST_DRIVE = 1'b0;
  localparam logic        RST_RX_V  = 1'b0;

endpackage

// File: rtl/bidir_tx_fifo.sv
// Transmit FIFO: power-of-two depth, head visible combinationally, level counts 0..TX_DEPTH.
module bidir_tx_fifo
  import bidir_pkg::*;
#(
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  parameter  int unsigned TX_DEPTH = 4,
  localparam int unsigned LVL_W    = $clog2(TX_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(TX_DEPTH);

  logic [DATA_W-1:0] mem_q [TX_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(TX_DEPTH));
  assign empty_o = (level_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Full/empty are judged before this cycle's pop, so a pop never frees room for a same-cycle push.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: resetting the level discards the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/bidir_dev_xcvr.sv
// Device-side bus transceiver: listens while the controller owns the bus, drives buffered words
// after a one-cycle turnaround once direction is handed over.
module bidir_dev_xcvr
  import bidir_pkg::*;
#(
  parameter  int unsigned DATA_W   = DATA_W_DEF,
  parameter  int unsigned TX_DEPTH = 4,
  localparam int unsigned LVL_W    = $clog2(TX_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dir,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_en,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic [LVL_W-1:0]  tx_level,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data
);

  xcvr_state_e       state_q, state_d;
  logic              dir_q;
  logic              drive_q;
  logic [DATA_W-1:0] bus_out_q;
  logic              rx_valid_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              pop_c, capture_c, push_c;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign tx_ready = ~fifo_full;
  assign push_c   = tx_valid & tx_ready;
  // Gated by dir directly so the bus is released in the very cycle the controller reclaims it.
  assign bus_en   = drive_q & ~dir;
  assign bus_out  = bus_out_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

  always_comb begin
    state_d   = state_q;
    pop_c     = 1'b0;
    capture_c = 1'b0;
    unique case (state_q)
      LISTEN: begin
        if (!dir) state_d = TURN;
        capture_c = dir & dir_q;
      end
      TURN: begin
        state_d = dir ? LISTEN : DRIVE;
        pop_c   = ~dir & ~fifo_empty;
      end
      DRIVE: begin
        if (dir) state_d = LISTEN;
        pop_c = ~dir & ~fifo_empty;
      end
      default: state_d = LISTEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_STATE;
      dir_q      <= RST_DIR_Q;
      drive_q    <= RST_DRIVE;
      bus_out_q  <= '0;
      rx_valid_q <= RST_RX_V;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir;
      drive_q    <= (state_d == DRIVE);
      rx_valid_q <= capture_c;
      if (pop_c)     bus_out_q <= fifo_head;
      if (capture_c) rx_data_q <= bus_in;
    end
  end

  bidir_tx_fifo #(
    .DATA_W  (DATA_W),
    .TX_DEPTH(TX_DEPTH)
  ) u_tx_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_c),
    .push_data_i(tx_data),
    .pop_i      (pop_c),
    .head_o     (fifo_head),
    .level_o    (tx_level),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

endmodule

// File: tb/tb_bidir_dev_xcvr.sv
// Directed bench for bidir_dev_xcvr: an ownership-history model checked every cycle plus literal pins.
module tb_bidir_dev_xcvr;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dir;
  logic [DW-1:0] bus_in;
  logic [DW-1:0] bus_out;
  logic          bus_en;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic [LW-1:0] tx_level;
  logic          rx_valid;
  logic [DW-1:0] rx_data;

  int n_checks = 0;
  int n_errors = 0;

  bidir_dev_xcvr #(.DATA_W(DW), .TX_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .dir     (dir),
    .bus_in  (bus_in),
    .bus_out (bus_out),
    .bus_en  (bus_en),
    .tx_valid(tx_valid),
    .tx_data (tx_data),
    .tx_ready(tx_ready),
    .tx_level(tx_level),
    .rx_valid(rx_valid),
    .rx_data (rx_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Model: the device owns the bus after dir was seen low on two consecutive edges, and listens
  // (capturing) after dir was seen high on two consecutive edges.
  logic          m_last_dir = 1'b1;
  logic          m_drive    = 1'b0;
  logic [DW-1:0] m_bus_out  = '0;
  logic          m_rx_valid = 1'b0;
  logic [DW-1:0] m_rx_data  = '0;
  logic [DW-1:0] m_q [$];
  bit            m_pop, m_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_last_dir = 1'b1;
      m_drive    = 1'b0;
      m_bus_out  = '0;
      m_rx_valid = 1'b0;
      m_rx_data  = '0;
      m_q.delete();
    end else begin
      m_pop      = !dir && !m_last_dir && (m_q.size() > 0);
      m_push     = tx_valid && (m_q.size() < DEPTH);
      m_rx_valid = dir && m_last_dir;
      if (m_rx_valid) m_rx_data = bus_in;
      m_drive    = !dir && !m_last_dir;
      if (m_pop)  m_bus_out = m_q.pop_front();
      if (m_push) m_q.push_back(tx_data);
      m_last_dir = dir;
    end
  end

  always @(negedge clk) begin
    check("bus_en",   32'(bus_en),   32'(m_drive && !dir));
    check("bus_out",  32'(bus_out),  32'(m_bus_out));
    check("tx_ready", 32'(tx_ready), 32'(m_q.size() < DEPTH));
    check("tx_level", 32'(tx_level), 32'(m_q.size()));
    check("rx_valid", 32'(rx_valid), 32'(m_rx_valid));
    if (m_rx_valid) check("rx_data", 32'(rx_data), 32'(m_rx_data));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; dir = 1'b1; bus_in = '0; tx_valid = 1'b0; tx_data = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    check("rst_bus_en",   32'(bus_en),   32'h0);
    check("rst_bus_out",  32'(bus_out),  32'h0);
    check("rst_tx_level", 32'(tx_level), 32'h0);
    check("rst_tx_ready", 32'(tx_ready), 32'h1);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_rx_data",  32'(rx_data),  32'h0);
    cyc();

    // Transmit after turnaround
    tx_valid = 1'b1; tx_data = 8'hA5; cyc();
    tx_data = 8'h5A; cyc();
    tx_data = 8'h3C; cyc();
    tx_valid = 1'b0;
    check("t3_level3", 32'(tx_level), 32'h3);
    dir = 1'b0; cyc();
    check("t3_turn_en", 32'(bus_en), 32'h0);
    cyc();
    check("t3_en1", 32'(bus_en), 32'h1);
    check("t3_A5",  32'(bus_out), 32'hA5);
    cyc(); check("t3_5A", 32'(bus_out), 32'h5A);
    cyc(); check("t3_3C", 32'(bus_out), 32'h3C);
    check("t3_level0", 32'(tx_level), 32'h0);
    cyc(); check("t3_hold", 32'(bus_out), 32'h3C);
    check("t3_hold_en", 32'(bus_en), 32'h1);

    // Receive with guard cycle, then reset mid-stream
    dir = 1'b1; bus_in = 8'hEE;
    #1; check("t2_release", 32'(bus_en), 32'h0);
    cyc();
    check("t2_guard_v", 32'(rx_valid), 32'h0);
    check("t2_guard_d", 32'(rx_data),  32'h0);
    bus_in = 8'h11; cyc();
    check("t2_v11", 32'(rx_valid), 32'h1); check("t2_d11", 32'(rx_data), 32'h11);
    bus_in = 8'h22; tx_valid = 1'b1; tx_data = 8'h77; cyc();
    tx_valid = 1'b0;
    check("t2_v22", 32'(rx_valid), 32'h1); check("t2_d22", 32'(rx_data), 32'h22);
    bus_in = 8'h33; cyc();
    check("t2_v33", 32'(rx_valid), 32'h1); check("t2_d33", 32'(rx_data), 32'h33);
    check("t2_level1", 32'(tx_level), 32'h1);
    bus_in = 8'h44;
    rst_n = 1'b0; #1;
    check("t1_bus_en",   32'(bus_en),   32'h0);
    check("t1_rx_valid", 32'(rx_valid), 32'h0);
    check("t1_tx_ready", 32'(tx_ready), 32'h1);
    check("t1_tx_level", 32'(tx_level), 32'h0);
    #2; rst_n = 1'b1;
    cyc();
    check("t1_after_d", 32'(rx_data), 32'h44);
    bus_in = '0;

    // Early release
    for (int i = 1; i <= 4; i++) begin
      tx_valid = 1'b1; tx_data = 8'(i); cyc();
    end
    tx_valid = 1'b0;
    check("t4_full_lvl", 32'(tx_level), 32'h4);
    check("t4_full_rdy", 32'(tx_ready), 32'h0);
    dir = 1'b0; cyc(); cyc();
    check("t4_01", 32'(bus_out), 32'h01);
    check("t4_en", 32'(bus_en), 32'h1);
    dir = 1'b1; #1;
    check("t4_release", 32'(bus_en), 32'h0);
    cyc();
    check("t4_level3", 32'(tx_level), 32'h3);
    dir = 1'b0; cyc();
    check("t4_turn_en", 32'(bus_en), 32'h0);
    check("t4_turn_out", 32'(bus_out), 32'h01);
    cyc(); check("t4_02", 32'(bus_out), 32'h02);
    cyc(); check("t4_03", 32'(bus_out), 32'h03);
    cyc(); check("t4_04", 32'(bus_out), 32'h04);
    check("t4_level0", 32'(tx_level), 32'h0);

    // FIFO full, overflow rejection, drain, streamed wrap, push+pop at level 2
    dir = 1'b1; cyc();
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1; tx_data = 8'(8'h10 + i); cyc();
      if (i == 3) check("t5_ready0", 32'(tx_ready), 32'h0);
    end
    tx_valid = 1'b0;
    check("t5_level4", 32'(tx_level), 32'h4);
    dir = 1'b0; cyc();
    for (int i = 0; i < 4; i++) begin
      cyc(); check("t5_drain", 32'(bus_out), 32'(8'h10 + i));
    end
    check("t5_empty", 32'(tx_level), 32'h0);
    for (int i = 0; i < 6; i++) begin
      tx_valid = 1'b1; tx_data = 8'(8'h40 + i); cyc();
      if (i > 0) check("t5_stream", 32'(bus_out), 32'(8'h40 + i - 1));
    end
    tx_valid = 1'b0; cyc();
    check("t5_last", 32'(bus_out), 32'h45);
    dir = 1'b1; cyc(); cyc();
    tx_valid = 1'b1; tx_data = 8'h30; cyc();
    tx_data = 8'h31; cyc();
    tx_valid = 1'b0;
    dir = 1'b0; cyc();
    check("t5_lvl2_pre", 32'(tx_level), 32'h2);
    tx_valid = 1'b1; tx_data = 8'h32; cyc();
    tx_valid = 1'b0;
    check("t5_pushpop_lvl", 32'(tx_level), 32'h2);
    check("t5_pushpop_out", 32'(bus_out), 32'h30);
    check("t5_pushpop_en",  32'(bus_en),  32'h1);

    // Reset during DRIVE with two words pending
    rst_n = 1'b0; #1;
    check("t6_bus_en",   32'(bus_en),   32'h0);
    check("t6_tx_level", 32'(tx_level), 32'h0);
    #2; rst_n = 1'b1;
    cyc();
    check("t6_turn_en", 32'(bus_en),   32'h0);
    check("t6_level",   32'(tx_level), 32'h0);
    check("t6_out",     32'(bus_out),  32'h0);
    cyc();
    check("t6_drive_empty_en",  32'(bus_en),  32'h1);
    check("t6_drive_empty_out", 32'(bus_out), 32'h0);
    dir = 1'b1; cyc(); cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bidir_dev_xcvr.md
# bidir_dev_xcvr

Device-side transceiver for the shared bidirectional bus whose direction is owned by the controller through `dir`. While `dir` is high the block listens and hands captured controller words to local logic. While `dir` is low it drives buffered device words back onto the bus, with a guarded turnaround so the two ends never drive together. It sits between the device's `inout` modport signals and device-local logic; the top-level tri-state is `bidir_data = bus_en ? bus_out : 'z`.

## Interface
- `DATA_W`, default 8: bus and word width.
- `TX_DEPTH`, default 4: transmit FIFO depth in words; must be a power of two and at least 2.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `dir`  in  1  bus direction from the controller: 1 = controller drives, 0 = device may drive. Synchronous to `clk`.
- `bus_in`  in  DATA_W  value currently on `bidir_data`.
- `bus_out`  out  DATA_W  value this block drives.
- `bus_en`  out  1  tri-state enable for `bus_out`.
- `tx_valid`  in  1  local push request.
- `tx_data`  in  DATA_W  push data.
- `tx_ready`  out  1  FIFO not full.
- `tx_level`  out  $clog2(TX_DEPTH)+1  FIFO occupancy.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` is a new captured word.
- `rx_data`  out  DATA_W  last captured controller word.

## Operation
- **States:** LISTEN, TURN, DRIVE. Reset state is LISTEN.
- **Transitions:**
  - LISTEN & !dir → TURN.
  - TURN & !dir → DRIVE.
  - TURN & dir → LISTEN.
  - DRIVE & dir → LISTEN.
  - All other cases hold the current state.
- **Drive enable:** `drive_q` is registered and set when the next state is DRIVE.
  - `bus_en = drive_q & ~dir` (combinational gate), so the bus is released in the same cycle `dir` rises.
  - `bus_en` is never 1 in LISTEN or TURN.
- **Pop:** a pop occurs in a cycle where the state is TURN or DRIVE, `dir`=0 and the FIFO is non-empty.
  - On a pop, `bus_out` <= FIFO head.
  - With the FIFO empty, `bus_out` holds its last value and nothing is popped.
- **Push:** a push occurs when `tx_valid & tx_ready`.
  - `tx_ready = (tx_level != TX_DEPTH)`, evaluated before any same-cycle pop; a pop does not free space for the same cycle.
  - Push and pop in the same cycle are both performed, and `tx_level` is unchanged.
- **Receive:** capture happens when state = LISTEN, `dir`=1 and `dir_q`=1, where `dir_q` is `dir` registered.
  - The first cycle after `dir` rises is a guard cycle and is never captured.
  - On capture, `rx_data` <= `bus_in` and `rx_valid` <= 1; otherwise `rx_valid` <= 0.
- **FIFO pointers:** pointers wrap modulo TX_DEPTH; `tx_level` ranges 0..TX_DEPTH.
- **Reset values:**
  - `bus_en`=0, `bus_out`=0, `rx_valid`=0, `rx_data`=0.
  - `tx_level`=0, `tx_ready`=1, state = LISTEN, `dir_q`=1.
- **Reset mid-operation:**
  - `bus_en` drops asynchronously.
  - FIFO contents are discarded.

## Timing
- **Turnaround:** if `dir` falls at edge N, the block is in TURN for cycle N..N+1 with `bus_en`=0. The first word is loaded at edge N+1 and `bus_en`=1 from N+1.
- **Transmit throughput:** one word per cycle while in DRIVE with `dir`=0 and data available.
- **Release latency:** 0 cycles from `dir` high to `bus_en` low, because the release is combinational.
- **Receive latency:** `rx_valid`/`rx_data` appear 1 cycle after the sampled `bus_in`. Throughput is one word per cycle after the guard cycle.
- **Push-to-level latency:** a push is visible on `tx_level` the next cycle.

## Structure
- **Package `bidir_pkg`:**
  - state enum `xcvr_state_e` {LISTEN, TURN, DRIVE};
  - default `DATA_W`;
  - reset constants.
- **Sub-module `bidir_tx_fifo`:**
  - synchronous FIFO parameterised by DATA_W/TX_DEPTH;
  - push/pop/head/level/full/empty ports;
  - same clock and reset as the parent.
- **Top:** the tri-state itself stays outside this block.

## Test plan
1. **Reset:** assert `rst_n`=0 mid-run → immediately `bus_en`=0, `rx_valid`=0, `tx_ready`=1, `tx_level`=0.
2. **Receive with guard cycle:** `dir` rises, `bus_in` = 0xEE in the guard cycle, then 0x11, 0x22, 0x33 → 0xEE is never captured; `rx_valid` pulses three consecutive cycles with 0x11, 0x22, 0x33, each one cycle late.
3. **Transmit after turnaround:** push 0xA5, 0x5A, 0x3C while `dir`=1, then drop `dir` → one TURN cycle with `bus_en`=0; then `bus_en`=1 with `bus_out` A5, 5A, 3C on successive cycles; `bus_out` then holds 0x3C; `tx_level` reaches 0.
4. **Early release:** push 0x01–0x04, drop `dir`, raise `dir` the cycle after 0x01 is driven → `bus_en` falls in that same cycle; `tx_level`=3; the next low `dir` resumes with 0x02 after TURN.
5. **FIFO full and wrap:**
   - push 5 words with TX_DEPTH=4 → `tx_ready`=0 after the fourth, and the fifth is not accepted;
   - drain, then repeat through a pointer wrap → order is preserved;
   - a simultaneous push and pop at level 2 leaves `tx_level`=2.
6. **Reset during DRIVE:** assert reset with 2 words pending → `bus_en`=0 asynchronously; after release, state is LISTEN and `tx_level`=0.
